// File: rtl/div_sequencer_pkg.sv
// Shared types for the RV32M divide sequencer: op encoding and FSM states.
package div_sequencer_pkg;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} div_state_t;

  // op[0] clear means signed, op[1] set means remainder is returned
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration; the quotient register doubles as the dividend shifter.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] dvs,
  output logic [DATA_WIDTH:0]   rem_nxt,
  output logic [DATA_WIDTH-1:0] quo_nxt
);
  logic [DATA_WIDTH+1:0] shf, diff;

  always_comb begin
    shf     = {rem, quo[DATA_WIDTH-1]};
    diff    = shf - {2'b00, dvs};
    rem_nxt = diff[DATA_WIDTH+1] ? shf[DATA_WIDTH:0] : diff[DATA_WIDTH:0];
    quo_nxt = {quo[DATA_WIDTH-2:0], ~diff[DATA_WIDTH+1]};
  end
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M div/rem sequencer: stalls the pipe while iterating, pulses valid_o once.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_ITERS  = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [4:0]            rd_in,
  input  logic                  flush,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out
);
  localparam int CW = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t            state;
  div_op_t               op_q;
  logic                  neg_q, valid_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH:0]   rem_q, rem_nxt;
  logic [DATA_WIDTH-1:0] quo_q, quo_nxt, dvs_q;
  logic [4:0]            rd_q;

  logic                  sgn, a_neg, b_neg, div_zero, ovf, accept, neg_in;
  logic [DATA_WIDTH-1:0] a_abs, b_abs, special_res, fin_q, fin_r, final_res;

  always_comb begin
    sgn         = op_is_signed(op);
    a_neg       = sgn & a[DATA_WIDTH-1];
    b_neg       = sgn & b[DATA_WIDTH-1];
    a_abs       = a_neg ? -a : a;
    b_abs       = b_neg ? -b : b;
    div_zero    = (b == '0);
    ovf         = sgn & (a == MIN_NEG) & (b == '1);
    accept      = (state == IDLE) & start & ~flush;
    neg_in      = op_is_rem(op) ? a_neg : (a_neg ^ b_neg);
    // divide-by-zero wins over overflow since b=0 can't also be -1
    special_res = op_is_rem(op) ? (div_zero ? a : '0) : (div_zero ? '1 : MIN_NEG);
    fin_q       = neg_q ? -quo_nxt : quo_nxt;
    fin_r       = neg_q ? -rem_nxt[DATA_WIDTH-1:0] : rem_nxt[DATA_WIDTH-1:0];
    final_res   = op_is_rem(op_q) ? fin_r : fin_q;
  end

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem(rem_q), .quo(quo_q), .dvs(dvs_q), .rem_nxt(rem_nxt), .quo_nxt(quo_nxt)
  );

  assign stall_o = accept | (state == BUSY);
  // a flush landing on the DONE cycle must still suppress the result
  assign valid_o = valid_q & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= DIV;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rd_q    <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q  <= div_op_t'(op);
          rd_q  <= rd_in;
          neg_q <= neg_in;
          cnt   <= '0;
          if (div_zero | ovf) begin
            result  <= special_res;
            rd_out  <= rd_in;
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            rem_q <= '0;
            quo_q <= a_abs;
            dvs_q <= b_abs;
            state <= BUSY;
          end
        end
        BUSY: if (flush) begin
          state <= IDLE;
        end else begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            result  <= final_res;
            rd_out  <= rd_q;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
